z80_bus_trace: RTL

//  Synthesisable bus-activity monitor for the Z80 test SoC. Samples the CPU control strobes, address and data

---
 rtl/z80_bus_trace_if.sv | 20 ++
 rtl/z80_bus_trace.sv | 96 +++++++++
 2 files changed

// File: rtl/z80_bus_trace_if.sv
// z80_bus_trace_if: Z80 CPU strobes/buses observed by the tracer plus the trace record stream
interface z80_bus_trace_if #(
    parameter int AW    = 16,
    parameter int DW    = 8,
    parameter int REC_W = 27
);
    logic             _reset, _m1, _rd, _wr, _mreq, _iorq, _halt;
    logic [AW-1:0]    ab;
    logic [DW-1:0]    db_i, db_o;
    logic             rec_valid, rec_ready;
    logic [REC_W-1:0] rec_data;
    modport master (
        output _reset, _m1, _rd, _wr, _mreq, _iorq, _halt, ab, db_i, db_o, rec_ready,
        input  rec_valid, rec_data
    );
    modport slave (
        input  _reset, _m1, _rd, _wr, _mreq, _iorq, _halt, ab, db_i, db_o, rec_ready,
        output rec_valid, rec_data
    );
endinterface

// File: rtl/z80_bus_trace.sv
// z80_bus_trace: Z80 bus event encoder into a show-ahead FIFO with halt watchdog; Z80_TRACE_TIMESTAMP_EN prepends a sample timestamp
module z80_bus_trace #(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int DEPTH      = 16,
    parameter int HALT_LIMIT = 10,
    parameter int OVF_W      = 8,
    parameter int TS_W       = 16
) (
    input  logic             eclk,
    input  logic             ereset,
    input  logic             clk,
    z80_bus_trace_if.slave   bus,
    output logic [OVF_W-1:0] overflow_cnt,
    output logic             halted,
    output logic             halt_done
);
`ifdef Z80_TRACE_TIMESTAMP_EN
    localparam int REC_W = TS_W + 3 + AW + DW;
`else
    localparam int REC_W = 3 + AW + DW + 0 * TS_W;
`endif
    localparam int PW = $clog2(DEPTH);
    localparam int HW = $clog2(HALT_LIMIT + 1);

    logic             clk_q, rd_l, wr_l, rst_l, halt_l;
    logic [REC_W-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [PW:0]      cnt;
    logic [HW-1:0]    hcnt;
    logic             sample, rst_a, rst_r, halt_e, wr_e, rd_e, any, push, pop, full, accept;
    logic [2:0]       typ, n_ev, lost;
    logic [DW-1:0]    data;
    logic [REC_W-1:0] rec;
    logic [OVF_W:0]   ovf_sum;

    always_comb begin
        sample        = clk & ~clk_q;
        rst_a         = rst_l & ~bus._reset;
        rst_r         = ~rst_l & bus._reset;
        halt_e        = halt_l & ~bus._halt;
        wr_e          = wr_l & ~bus._wr & ~(bus._mreq & bus._iorq);
        rd_e          = rd_l & ~bus._rd & ~(bus._mreq & bus._iorq);
        n_ev          = 3'(rst_a) + 3'(rst_r) + 3'(halt_e) + 3'(wr_e) + 3'(rd_e);
        any           = n_ev != 3'd0;
        typ           = rst_a ? 3'd5 : rst_r ? 3'd6 : halt_e ? 3'd7 :
                        wr_e ? (~bus._mreq ? 3'd3 : 3'd4) :
                        ~bus._mreq ? {2'b00, bus._m1} : 3'd2;
        data          = (wr_e & ~(rst_a | rst_r | halt_e)) ? bus.db_o : bus.db_i;
        full          = cnt == (PW + 1)'(DEPTH);
        pop           = (cnt != '0) & bus.rec_ready;
        push          = sample & any;
        accept        = push & (~full | pop);
        // every qualifying event beyond the winner, plus a winner refused by a full FIFO, is lost
        lost          = sample ? n_ev - 3'(any) + 3'(push & ~accept) : 3'd0;
        ovf_sum       = {1'b0, overflow_cnt} + (OVF_W + 1)'(lost);
        bus.rec_valid = cnt != '0;
        bus.rec_data  = bus.rec_valid ? mem[rd_ptr] : '0;
    end

`ifdef Z80_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
    always_ff @(posedge eclk) ts <= ereset ? '0 : ts + TS_W'(sample);
    assign rec = {ts, typ, bus.ab, data};
`else
    assign rec = {typ, bus.ab, data};
`endif

    always_ff @(posedge eclk) begin
        if (ereset) begin
            clk_q                        <= 1'b0;
            {rd_l, wr_l, rst_l, halt_l}  <= '1;
            rd_ptr                       <= '0;
            wr_ptr                       <= '0;
            cnt                          <= '0;
            overflow_cnt                 <= '0;
            halted                       <= 1'b0;
            halt_done                    <= 1'b0;
            hcnt                         <= '0;
        end else begin
            clk_q        <= clk;
            rd_ptr       <= rd_ptr + PW'(pop);
            wr_ptr       <= wr_ptr + PW'(accept);
            cnt          <= cnt + (PW + 1)'(accept) - (PW + 1)'(pop);
            overflow_cnt <= ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
            if (sample) begin
                {rd_l, wr_l, rst_l, halt_l} <= {bus._rd, bus._wr, bus._reset, bus._halt};
                halted    <= ~bus._halt;
                hcnt      <= bus._halt ? '0 : (hcnt == HW'(HALT_LIMIT) ? hcnt : hcnt + 1'b1);
                halt_done <= halt_done | (~bus._halt & (hcnt >= HW'(HALT_LIMIT - 1)));
            end
        end
    end

    always_ff @(posedge eclk) if (accept) mem[wr_ptr] <= rec;
endmodule
